// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller.
package mem_access_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable up-counter with a terminal-count flag, paces SRAM wait states.
module mem_wait_counter #(
  parameter int unsigned     WIDTH    = 2,
  parameter logic [WIDTH-1:0] TERMINAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/mem_access_controller.sv
// Sequences pipeline loads/stores onto a fixed-wait-state word SRAM and
// freezes the pipeline through ready while an access is in flight.
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned WORD_COUNT  = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  output logic [31:0]       readData,
  output logic              ready,
  output logic              addrErr,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [31:0]       sramWData,
  output logic              sramWE,
  output logic              sramOE,
  input  logic [31:0]       sramRData
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  state_t      state_q, state_d;
  logic        req;
  logic        is_write_q;
  logic        err_q;
  logic        tc;
  logic        cnt_load;
  logic        cnt_en;
  logic [29:0] word_idx;
  logic        in_range;

  assign req = MEM_R_EN | MEM_W_EN;

  // Wrapped (below-base) offsets land far above WORD_COUNT, so one compare covers both ends.
  assign word_idx = 30'((ALU_Res - BASE_ADDR) >> 2);
  assign in_range = (word_idx < 30'(WORD_COUNT));

  mem_wait_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (CNT_W'(WAIT_CYCLES - 1))
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .tc       (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        ready    = ~req;
        cnt_load = 1'b1;
        if (req) state_d = ACCESS;
      end
      ACCESS: begin
        cnt_en = 1'b1;
        if (tc) state_d = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readData   <= '0;
      addrErr    <= 1'b0;
      sramAddr   <= '0;
      sramWData  <= '0;
      sramWE     <= 1'b0;
      sramOE     <= 1'b0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addrErr <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            is_write_q <= MEM_W_EN;
            sramAddr   <= word_idx[ADDR_W-1:0];
            sramWData  <= Val_Rm;
            err_q      <= ~in_range;
            sramWE     <= MEM_W_EN & in_range;
            sramOE     <= ~MEM_W_EN & in_range;
          end
        end
        ACCESS: begin
          if (tc) begin
            sramWE  <= 1'b0;
            sramOE  <= 1'b0;
            addrErr <= err_q;
            if (!is_write_q) readData <= err_q ? '0 : sramRData;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
